// File: rtl/synth_pkg.sv
// Shared definitions for the polyphonic voice engine:
// register map, control bit positions, wave encoding, sweep FSM states.
package synth_pkg;

  localparam logic [3:0] A_FREQ0 = 4'd0;
  localparam logic [3:0] A_FREQ1 = 4'd1;
  localparam logic [3:0] A_FREQ2 = 4'd2;
  localparam logic [3:0] A_FREQ3 = 4'd3;
  localparam logic [3:0] A_DUTY  = 4'd4;
  localparam logic [3:0] A_CTRL  = 4'd5;
  localparam logic [3:0] A_ATK   = 4'd6;
  localparam logic [3:0] A_REL   = 4'd7;
  localparam logic [3:0] A_VOL   = 4'd8;
  localparam logic [3:0] A_CLR   = 4'd9;

  localparam int C_EN      = 0;
  localparam int C_WAVE_LO = 1;
  localparam int C_WAVE_HI = 2;
  localparam int C_GATE    = 3;

  typedef enum logic [1:0] {
    W_SQUARE = 2'b00,
    W_SAW    = 2'b01,
    W_TRI    = 2'b10,
    W_OFF    = 2'b11
  } wave_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_e;

endpackage

// File: rtl/wave_shaper.sv
// Combinational waveform generator: top phase byte, duty and
// wave select in, 8-bit unsigned wave sample out.
module wave_shaper
  import synth_pkg::*;
(
  input  logic [7:0] p,
  input  logic [7:0] duty,
  input  wave_e      sel,
  output logic [7:0] wave
);

  logic [7:0] ramp;

  assign ramp = {p[6:0], 1'b0};

  always_comb begin
    wave = 8'd0;
    unique case (sel)
      W_SQUARE: wave = (p < duty) ? 8'hff : 8'h00;
      W_SAW:    wave = p;
      W_TRI:    wave = p[7] ? ~ramp : ramp;
      default:  wave = 8'd0;
    endcase
  end

endmodule

// File: rtl/poly_voice_engine.sv
// Time-multiplexed polyphonic oscillator: one voice per cycle,
// summed and volume-scaled into one sample per sample_tick.
module poly_voice_engine
  import synth_pkg::*;
#(
  parameter  int VOICES  = 4,
  parameter  int PHASE_W = 24,
  localparam int VI_W    = (VOICES > 1) ? $clog2(VOICES) : 1,
  localparam int MIX_W   = 8 + $clog2(VOICES)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_we,
  input  logic [VI_W-1:0]   cfg_voice,
  input  logic [3:0]        cfg_addr,
  input  logic [7:0]        cfg_wdata,
  input  logic [VOICES-1:0] gate,
  input  logic              sample_tick,
  output logic [MIX_W-1:0]  mix_out,
  output logic              mix_valid,
  output logic [VOICES-1:0] voice_active,
  output logic              overrun
);

  localparam int NB = PHASE_W / 8;

  logic [PHASE_W-1:0] freq_q  [VOICES];
  logic [PHASE_W-1:0] phase_q [VOICES];
  logic [7:0]         duty_q  [VOICES];
  logic [3:0]         ctrl_q  [VOICES];
  logic [7:0]         atk_q   [VOICES];
  logic [7:0]         rel_q   [VOICES];
  logic [7:0]         env_q   [VOICES];
  logic [7:0]         vol_q;

  state_e             state_q, state_d;
  logic [VI_W-1:0]    v_q;
  logic [MIX_W-1:0]   acc_q;

  logic               cfg_hit;
  logic               g_v, en_v, last;
  logic [7:0]         p_v, wave_raw, wave_v;
  logic [7:0]         env_old, env_nxt;
  logic [8:0]         env_sum;
  logic [15:0]        prod;
  logic [MIX_W-1:0]   acc_nxt;
  logic [MIX_W+7:0]   scaled;

  assign cfg_hit = cfg_we && (cfg_voice <= VI_W'(VOICES - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      vol_q <= 8'd0;
      for (int i = 0; i < VOICES; i++) begin
        freq_q[i] <= '0;
        duty_q[i] <= 8'd0;
        ctrl_q[i] <= 4'd0;
        atk_q[i]  <= 8'd0;
        rel_q[i]  <= 8'd0;
      end
    end else if (cfg_we) begin
      for (int b = 0; b < NB; b++)
        if (cfg_hit && cfg_addr == 4'(b))
          freq_q[cfg_voice][b*8 +: 8] <= cfg_wdata;
      if (cfg_hit && cfg_addr == A_DUTY)
        duty_q[cfg_voice] <= cfg_wdata;
      if (cfg_hit && cfg_addr == A_CTRL)
        ctrl_q[cfg_voice] <= cfg_wdata[3:0];
      if (cfg_hit && cfg_addr == A_ATK)
        atk_q[cfg_voice] <= cfg_wdata;
      if (cfg_hit && cfg_addr == A_REL)
        rel_q[cfg_voice] <= cfg_wdata;
      if (cfg_addr == A_VOL)
        vol_q <= cfg_wdata;
    end
  end

  assign g_v     = gate[v_q] | ctrl_q[v_q][C_GATE];
  assign en_v    = ctrl_q[v_q][C_EN];
  assign p_v     = phase_q[v_q][PHASE_W-1 -: 8];
  assign env_old = env_q[v_q];
  assign last    = (v_q == VI_W'(VOICES - 1));

  wave_shaper u_shaper (
    .p    (p_v),
    .duty (duty_q[v_q]),
    .sel  (wave_e'(ctrl_q[v_q][C_WAVE_HI:C_WAVE_LO])),
    .wave (wave_raw)
  );

  assign wave_v  = en_v ? wave_raw : 8'd0;
  assign env_sum = {1'b0, env_old} + {1'b0, atk_q[v_q]};

  // Rate 0 means an instantaneous jump in either direction.
  always_comb begin
    env_nxt = env_old;
    if (g_v) begin
      if (atk_q[v_q] == 8'd0 || env_sum[8])
        env_nxt = 8'hff;
      else
        env_nxt = env_sum[7:0];
    end else begin
      if (rel_q[v_q] == 8'd0 || env_old <= rel_q[v_q])
        env_nxt = 8'd0;
      else
        env_nxt = env_old - rel_q[v_q];
    end
  end

  assign prod    = wave_v * env_old;
  assign acc_nxt = acc_q + MIX_W'(prod[15:8]);
  assign scaled  = acc_nxt * vol_q;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (sample_tick) state_d = S_RUN;
      S_RUN:   if (last) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // The final sum is scaled on the last voice so mix_out is live in DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      v_q          <= '0;
      acc_q        <= '0;
      mix_out      <= '0;
      mix_valid    <= 1'b0;
      voice_active <= '0;
      for (int i = 0; i < VOICES; i++) begin
        phase_q[i] <= '0;
        env_q[i]   <= 8'd0;
      end
    end else begin
      mix_valid <= 1'b0;
      if (state_q == S_IDLE && sample_tick) begin
        acc_q <= '0;
        v_q   <= '0;
      end else if (state_q == S_RUN) begin
        acc_q             <= acc_nxt;
        env_q[v_q]        <= env_nxt;
        voice_active[v_q] <= g_v | (env_nxt != 8'd0);
        if (en_v)
          phase_q[v_q] <= phase_q[v_q] + freq_q[v_q];
        v_q <= last ? '0 : v_q + 1'b1;
        if (last) begin
          mix_out   <= scaled[MIX_W+7:8];
          mix_valid <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      overrun <= 1'b0;
    else if (sample_tick && state_q != S_IDLE)
      overrun <= 1'b1;
    else if (cfg_we && cfg_addr == A_CLR)
      overrun <= 1'b0;
  end

endmodule

// File: tb/tb_poly_voice_engine.sv
// Directed, table-driven bench for poly_voice_engine
// (VOICES=4, PHASE_W=24).
module tb_poly_voice_engine;

  localparam int VOICES  = 4;
  localparam int PHASE_W = 24;
  localparam int VI_W    = 2;
  localparam int MIX_W   = 10;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              cfg_we = 1'b0;
  logic [VI_W-1:0]   cfg_voice = '0;
  logic [3:0]        cfg_addr = '0;
  logic [7:0]        cfg_wdata = '0;
  logic [VOICES-1:0] gate = '0;
  logic              sample_tick = 1'b0;
  logic [MIX_W-1:0]  mix_out;
  logic              mix_valid;
  logic [VOICES-1:0] voice_active;
  logic              overrun;

  int n_chk = 0;
  int n_fail = 0;

  typedef struct {
    logic [3:0] gate;
    int          exp_mix;
    logic [3:0]  exp_act;
  } vec_t;

  vec_t t_saw [6];
  vec_t t_env [9];

  poly_voice_engine #(.VOICES(VOICES), .PHASE_W(PHASE_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .cfg_we       (cfg_we),
    .cfg_voice    (cfg_voice),
    .cfg_addr     (cfg_addr),
    .cfg_wdata    (cfg_wdata),
    .gate         (gate),
    .sample_tick  (sample_tick),
    .mix_out      (mix_out),
    .mix_valid    (mix_valid),
    .voice_active (voice_active),
    .overrun      (overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic wr(input int v, input int a, input int d);
    cfg_we    = 1'b1;
    cfg_voice = VI_W'(v);
    cfg_addr  = 4'(a);
    cfg_wdata = 8'(d);
    step();
    cfg_we = 1'b0;
  endtask

  task automatic wait_valid();
    int n = 0;
    while (!mix_valid && n < 40) begin
      step();
      n++;
    end
    if (!mix_valid) chk("valid_timeout", 0, 1);
    step();
  endtask

  task automatic sweep(output int mix);
    int n = 1;
    sample_tick = 1'b1;
    step();
    sample_tick = 1'b0;
    while (!mix_valid && n < 40) begin
      step();
      n++;
    end
    chk("latency", n, VOICES + 1);
    mix = int'(mix_out);
    step();
  endtask

  initial begin
    int m;
    int mv_seen;

    t_saw[0] = '{4'b0001, 0, 4'b0001};
    t_saw[1] = '{4'b0001, 0, 4'b0001};
    t_saw[2] = '{4'b0001, 0, 4'b0001};
    t_saw[3] = '{4'b0001, 1, 4'b0001};
    t_saw[4] = '{4'b0001, 2, 4'b0001};
    t_saw[5] = '{4'b0001, 3, 4'b0001};

    t_env[0] = '{4'b0010, 0,   4'b0010};
    t_env[1] = '{4'b0010, 62,  4'b0010};
    t_env[2] = '{4'b0010, 126, 4'b0010};
    t_env[3] = '{4'b0010, 190, 4'b0010};
    t_env[4] = '{4'b0010, 253, 4'b0010};
    t_env[5] = '{4'b0000, 253, 4'b0010};
    t_env[6] = '{4'b0000, 153, 4'b0010};
    t_env[7] = '{4'b0000, 53,  4'b0000};
    t_env[8] = '{4'b0000, 0,   4'b0000};

    do_reset();
    chk("rst_mix_out", int'(mix_out), 0);
    chk("rst_mix_valid", int'(mix_valid), 0);
    chk("rst_active", int'(voice_active), 0);
    chk("rst_overrun", int'(overrun), 0);

    sweep(m);
    chk("idle_mix", m, 0);
    chk("idle_active", int'(voice_active), 0);

    // Voice 0 saw, one phase-byte step per sample, instant attack.
    wr(0, 8, 255);
    wr(0, 2, 1);
    wr(0, 6, 0);
    wr(0, 5, 3);
    for (int k = 0; k < 6; k++) begin
      gate = t_saw[k].gate;
      sweep(m);
      chk($sformatf("saw_mix[%0d]", k), m, t_saw[k].exp_mix);
      chk($sformatf("saw_act[%0d]", k), int'(voice_active),
          int'(t_saw[k].exp_act));
    end

    // Voice 1 square with attack 64 / release 100 envelope.
    gate = '0;
    do_reset();
    wr(0, 8, 255);
    wr(1, 4, 128);
    wr(1, 6, 64);
    wr(1, 7, 100);
    wr(1, 5, 1);
    for (int k = 0; k < 9; k++) begin
      gate = t_env[k].gate;
      sweep(m);
      chk($sformatf("env_mix[%0d]", k), m, t_env[k].exp_mix);
      chk($sformatf("env_act[%0d]", k), int'(voice_active),
          int'(t_env[k].exp_act));
    end

    // All four voices full square, volume 128.
    gate = '0;
    do_reset();
    wr(0, 8, 128);
    for (int v = 0; v < VOICES; v++) begin
      wr(v, 4, 255);
      wr(v, 6, 0);
      wr(v, 5, 1);
    end
    gate = 4'hf;
    sweep(m);
    chk("quad_mix0", m, 0);
    sweep(m);
    chk("quad_mix1", m, 508);
    chk("quad_act", int'(voice_active), 15);

    // Tick two cycles into a sweep is dropped.
    sample_tick = 1'b1;
    step();
    sample_tick = 1'b0;
    step();
    sample_tick = 1'b1;
    step();
    sample_tick = 1'b0;
    chk("overrun_set", int'(overrun), 1);
    wait_valid();
    chk("overrun_hold", int'(overrun), 1);
    wr(2, 9, 0);
    chk("overrun_clr", int'(overrun), 0);

    // Clear write and dropped tick in the same cycle: set wins.
    sample_tick = 1'b1;
    step();
    sample_tick = 1'b1;
    cfg_we      = 1'b1;
    cfg_addr    = 4'd9;
    step();
    sample_tick = 1'b0;
    cfg_we      = 1'b0;
    chk("overrun_set_wins", int'(overrun), 1);
    wait_valid();
    wr(0, 9, 0);
    chk("overrun_clr2", int'(overrun), 0);

    // Reset mid-sweep aborts and restarts phases.
    gate = '0;
    do_reset();
    wr(0, 8, 255);
    wr(0, 2, 64);
    wr(0, 6, 0);
    wr(0, 5, 3);
    gate = 4'b0001;
    sweep(m);
    sweep(m);
    sample_tick = 1'b1;
    step();
    sample_tick = 1'b0;
    step();
    gate = '0;
    rst  = 1'b1;
    mv_seen = int'(mix_valid);
    step();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (mix_valid) mv_seen++;
      step();
    end
    chk("abort_no_valid", mv_seen, 0);
    chk("abort_mix_out", int'(mix_out), 0);
    chk("abort_active", int'(voice_active), 0);
    chk("abort_overrun", int'(overrun), 0);

    wr(0, 8, 255);
    wr(0, 2, 64);
    wr(0, 6, 0);
    wr(0, 5, 3);
    gate = 4'b0001;
    sweep(m);
    chk("restart_mix0", m, 0);
    sweep(m);
    chk("restart_mix1", m, 62);

    // Switch to triangle at phase byte 128, then 192.
    wr(0, 5, 5);
    sweep(m);
    chk("tri_mix0", m, 253);
    sweep(m);
    chk("tri_mix1", m, 125);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
